// File: rtl/pwm_duty_sequencer_if.sv
// Pad-side controls into the duty sequencer and committed duty out to the PWM comparator.
interface pwm_duty_sequencer_if #(
  parameter int DUTY_W = 4
) ();
  logic              btn_up;
  logic              btn_dn;
  logic              mode;
  logic              period_start;
  logic [DUTY_W-1:0] duty;
  logic              duty_upd;
  logic [1:0]        state;

  modport master (
    output btn_up, btn_dn, mode, period_start,
    input  duty, duty_upd, state
  );

  modport slave (
    input  btn_up, btn_dn, mode, period_start,
    output duty, duty_upd, state
  );
endinterface

// File: rtl/pwm_duty_sequencer.sv
// Button-driven / breathing-ramp duty controller for the 10-step PWM generator.
// Duty, its update strobe and the FSM state change only on PWM period boundaries.

// One button: 2-flop synchronizer, stability-counter debouncer, rising-edge strobe.
module pwm_duty_sequencer_deb #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_rise
);
  localparam int DCW = $clog2(DEB_CYCLES + 1);
  localparam logic [DCW-1:0] L_DEB = DCW'(DEB_CYCLES);
  localparam logic [DCW-1:0] L_ONE = DCW'(1);

  logic [1:0]     r_sync;
  logic [DCW-1:0] r_cnt;
  logic           r_deb;
  logic           r_deb_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync  <= 2'b00;
      r_cnt   <= '0;
      r_deb   <= 1'b0;
      r_deb_q <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_deb_q <= r_deb;
      // The level is accepted only after the counter has held DEB_CYCLES for a cycle.
      if (r_sync[1] == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == L_DEB) begin
        r_deb <= ~r_deb;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + L_ONE;
      end
    end
  end

  assign o_rise = r_deb & ~r_deb_q;
endmodule

module pwm_duty_sequencer #(
  parameter int DUTY_W       = 4,
  parameter int DUTY_MIN     = 1,
  parameter int DUTY_MAX     = 9,
  parameter int DUTY_RST     = 5,
  parameter int DEB_CYCLES   = 16,
  parameter int STEP_PERIODS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pwm_duty_sequencer_if.slave   bus
);
  localparam int NUM_BTN = 2;
  localparam int BTN_UP  = 0;
  localparam int BTN_DN  = 1;
  localparam int PCW     = $clog2(STEP_PERIODS + 1);

  localparam logic [DUTY_W-1:0] L_MIN  = DUTY_W'(DUTY_MIN);
  localparam logic [DUTY_W-1:0] L_MAX  = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] L_RST  = DUTY_W'(DUTY_RST);
  localparam logic [DUTY_W-1:0] L_D1   = DUTY_W'(1);
  localparam logic [PCW-1:0]    L_STEP = PCW'(STEP_PERIODS);
  localparam logic [PCW-1:0]    L_P1   = PCW'(1);

  typedef enum logic [1:0] {
    ST_MANUAL  = 2'b00,
    ST_RAMP_UP = 2'b01,
    ST_RAMP_DN = 2'b10
  } state_e;

  logic [NUM_BTN-1:0] w_btn;
  logic [NUM_BTN-1:0] w_rise;
  logic [NUM_BTN-1:0] r_pend;
  logic [NUM_BTN-1:0] w_req;

  state_e            r_state, w_state_nxt;
  logic [DUTY_W-1:0] r_duty,  w_duty_nxt;
  logic [PCW-1:0]    r_pcnt,  w_pcnt_nxt;
  logic              r_upd;
  logic [PCW-1:0]    w_pcnt_inc;
  logic [DUTY_W-1:0] w_up_val;
  logic [DUTY_W-1:0] w_dn_val;

  assign w_btn[BTN_UP] = bus.btn_up;
  assign w_btn[BTN_DN] = bus.btn_dn;

  genvar g;
  generate
    for (g = 0; g < NUM_BTN; g++) begin : g_btn
      pwm_duty_sequencer_deb #(
        .DEB_CYCLES (DEB_CYCLES)
      ) u_deb (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_btn  (w_btn[g]),
        .o_rise (w_rise[g])
      );
    end
  endgenerate

  // A press landing in the boundary cycle itself still counts at that boundary.
  assign w_req = r_pend | w_rise;

  always_ff @(posedge clk) begin
    if (!rst_n)                r_pend <= '0;
    else if (bus.period_start) r_pend <= '0;
    else                       r_pend <= w_req;
  end

  // Saturating neighbours of the current duty; they also pull an out-of-range value back in.
  assign w_up_val   = (r_duty < L_MIN) ? L_MIN :
                      (r_duty < L_MAX) ? r_duty + L_D1 : L_MAX;
  assign w_dn_val   = (r_duty > L_MAX) ? L_MAX :
                      (r_duty > L_MIN) ? r_duty - L_D1 : L_MIN;
  assign w_pcnt_inc = r_pcnt + L_P1;

  always_comb begin
    w_state_nxt = r_state;
    w_duty_nxt  = r_duty;
    w_pcnt_nxt  = r_pcnt;
    if (bus.period_start) begin
      unique case (r_state)
        ST_MANUAL: begin
          if (bus.mode) begin
            w_state_nxt = ST_RAMP_UP;
            w_pcnt_nxt  = '0;
          end else if (w_req[BTN_UP] && !w_req[BTN_DN] && r_duty < L_MAX) begin
            w_duty_nxt = w_up_val;
          end else if (w_req[BTN_DN] && !w_req[BTN_UP] && r_duty > L_MIN) begin
            w_duty_nxt = w_dn_val;
          end
        end
        ST_RAMP_UP, ST_RAMP_DN: begin
          if (!bus.mode) begin
            w_state_nxt = ST_MANUAL;
            w_pcnt_nxt  = '0;
          end else if (w_pcnt_inc != L_STEP) begin
            w_pcnt_nxt = w_pcnt_inc;
          end else begin
            w_pcnt_nxt = '0;
            // Go up when ramping up below the top, or ramping down already at the floor.
            if ((r_state == ST_RAMP_UP && r_duty < L_MAX) ||
                (r_state == ST_RAMP_DN && r_duty <= L_MIN)) begin
              w_duty_nxt  = w_up_val;
              w_state_nxt = (w_up_val == L_MAX) ? ST_RAMP_DN : ST_RAMP_UP;
            end else begin
              w_duty_nxt  = w_dn_val;
              w_state_nxt = (w_dn_val == L_MIN) ? ST_RAMP_UP : ST_RAMP_DN;
            end
          end
        end
        default: begin
          w_state_nxt = ST_MANUAL;
          w_pcnt_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_MANUAL;
      r_duty  <= L_RST;
      r_pcnt  <= '0;
      r_upd   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_duty  <= w_duty_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_upd   <= (w_duty_nxt != r_duty);
    end
  end

  assign bus.duty     = r_duty;
  assign bus.duty_upd = r_upd;
  assign bus.state    = r_state;
endmodule

// File: doc/pwm_duty_sequencer.md
# pwm_duty_sequencer

Controller that owns the duty-cycle setting of the 10-step PWM generator. It debounces the up/down push-buttons and turns them into single-step duty changes. It also provides an automatic triangular ramp ("breathing") mode. Every duty change is committed only on a PWM period boundary, so the generator never sees a mid-period update. It sits between the pad inputs and the PWM counter/comparator, which reads `duty` directly.

## Interface

**Parameters**
- `DUTY_W`, default 4: width of the duty value.
- `DUTY_MIN`, default 1: lowest duty step.
- `DUTY_MAX`, default 9: highest duty step.
- `DUTY_RST`, default 5: duty value after reset (50 %).
- `DEB_CYCLES`, default 16: consecutive stable cycles needed to accept a button level change.
- `STEP_PERIODS`, default 4: number of PWM periods per duty step in ramp mode.

**Ports**
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset; synchronous, active-low.
- `btn_up`, in, 1: raw asynchronous increase button.
- `btn_dn`, in, 1: raw asynchronous decrease button.
- `mode`, in, 1: 0 = manual, 1 = ramp. Quasi-static; sampled only on `period_start`.
- `period_start`, in, 1: 1-cycle pulse from the PWM generator in the cycle its counter wraps to 0.
- `duty`, out, DUTY_W: committed duty step, driven to the PWM comparator.
- `duty_upd`, out, 1: 1-cycle pulse in the cycle `duty` takes a new value.
- `state`, out, 2: 00 MANUAL, 01 RAMP_UP, 10 RAMP_DN.

## Operation

**Input conditioning (per button)**
- Each button passes through a 2-flop synchronizer, then a debouncer.
- The debouncer keeps a counter of width ceil(log2(DEB_CYCLES+1)).
  - The counter clears whenever the synced level equals the debounced level.
  - Otherwise it increments. When it reaches DEB_CYCLES, the debounced level flips and the counter clears.
- A 0→1 edge of the debounced level sets a pending flag (`pend_up` / `pend_dn`).
- Flags are sticky until the next `period_start` and are not counted: multiple presses before a boundary yield one step.

**FSM**, evaluated only in cycles with `period_start`=1 (all other cycles hold state, duty and the period counter)
- **MANUAL**
  - If `mode`=1: go to RAMP_UP, clear the period counter, clear the pending flags, no duty change this boundary.
  - Else, with `pend_up` only: if duty < DUTY_MAX then duty+1.
  - With `pend_dn` only: if duty > DUTY_MIN then duty−1.
  - With both flags set: no change.
  - Both flags clear at every boundary, whether or not a change happened.
- **RAMP_UP / RAMP_DN**
  - If `mode`=0: go to MANUAL, keep duty, clear the period counter.
  - Else increment the period counter. When it reaches STEP_PERIODS, clear it and step duty by ±1.
  - In RAMP_UP, a step that lands on DUTY_MAX switches to RAMP_DN. In RAMP_DN, a step that lands on DUTY_MIN switches to RAMP_UP.
  - An out-of-range duty on entry (for example duty = DUTY_MAX entering RAMP_UP) turns direction at the first step without exceeding the limit.
  - Pending flags are cleared every boundary; buttons have no effect in ramp mode.

**Arithmetic and outputs**
- Duty is always clamped to [DUTY_MIN, DUTY_MAX]. It never wraps.
- The period counter is ceil(log2(STEP_PERIODS+1)) bits.
- `duty_upd` is asserted only when the value actually changes. A saturated request or a mode switch does not pulse it.

## Timing

- Reset values: `duty`=DUTY_RST, `duty_upd`=0, `state`=00, pending flags 0, debounced levels 0, all counters 0, synchronizer flops 0.
- Debounce latency: a raw level change held stable is reflected in the debounced level 2+DEB_CYCLES cycles after it is first sampled. A glitch shorter than DEB_CYCLES synced cycles is ignored.
- The pending flag sets on the edge after the debounced level rises.
- Commit: `duty`, `duty_upd` and `state` update on the clock edge that samples `period_start`=1. `duty_upd` is high for exactly the following cycle.
- The generator therefore sees the new duty from cycle 0 of the next period.
- A flag set in the same cycle as `period_start` is applied at that boundary. The set and clear race resolves as "apply then clear".
- `rst_n`=0 mid-ramp or mid-debounce restores all reset values on the next edge, regardless of `period_start`.

## Test plan

- **Manual increase.** Reset, then hold `btn_up` for 40 cycles with `period_start` every 10 cycles.
  - Required: `duty` goes 5→6 exactly once, with one `duty_upd` pulse aligned to a `period_start`.
- **Bounce rejection and saturation.** Toggle `btn_dn` every 5 cycles (shorter than DEB_CYCLES): no change. Then press `btn_dn` cleanly 6 times with boundaries in between.
  - Required: duty 5→4→3→2→1→1→1; no `duty_upd` on the saturated presses.
- **Simultaneous requests.** Press up and down with both debounced before the same boundary.
  - Required: duty unchanged, no `duty_upd`, both flags cleared.
- **Ramp triangle.** Set `mode`=1 at duty 5 with STEP_PERIODS=4.
  - Required: state 01 after one boundary; duty 6,7,8,9 every 4 periods; state 10 at 9; then 8…1; state 01 at 1.
  - Button presses during the ramp have no effect.
- **Mode exit and reset mid-operation.** Clear `mode` mid-ramp at duty 7.
  - Required: state 00 and duty held at 7 from the next boundary.
  - Then assert `rst_n`=0 for 1 cycle mid-debounce: duty=5, state=00, no spurious step after release.
